// File: rtl/mult_div_unit_if.sv
// Purpose: bus between the ID/EX controller and the multiply/divide unit.
// Signals:
//   start   - launch the op in mdu_op this cycle
//   mdu_op  - 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved
//   src_a   - rs operand
//   src_b   - rt operand
//   rd_hi   - mdu_out select, 1 = HI, 0 = LO
//   busy    - operation in flight
//   hi, lo  - HI/LO architectural registers
//   mdu_out - combinational rd_hi ? hi : lo
interface mult_div_unit_if;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 3;

    logic              start;
    logic [OP_W-1:0]   mdu_op;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic              rd_hi;
    logic              busy;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic [DATA_W-1:0] mdu_out;

    modport master (
        output start, mdu_op, src_a, src_b, rd_hi,
        input  busy, hi, lo, mdu_out
    );

    modport slave (
        input  start, mdu_op, src_a, src_b, rd_hi,
        output busy, hi, lo, mdu_out
    );
endinterface

// File: rtl/mult_div_unit.sv
// Purpose: EX-stage MIPS multiply/divide unit with fixed multi-cycle latency.
//   The full result is computed and held at the start edge; HI/LO are written
//   when the cycle counter expires, giving the pipeline a deterministic busy window.
// Ports:
//   clk   - clock, all state on rising edge
//   reset - synchronous active-high reset
//   bus   - mult_div_unit_if.slave (start/mdu_op/src_a/src_b/rd_hi in,
//           busy/hi/lo/mdu_out out)
module mult_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    mult_div_unit_if.slave        bus
);
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = ($clog2(MAX_CYCLES) < 4) ? 4 : $clog2(MAX_CYCLES);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e              r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic [DATA_W-1:0]   r_hi, w_hi_nxt;
    logic [DATA_W-1:0]   r_lo, w_lo_nxt;
    logic [DATA_W-1:0]   r_hold_hi, w_hold_hi_nxt;
    logic [DATA_W-1:0]   r_hold_lo, w_hold_lo_nxt;
    logic                r_hold_wr, w_hold_wr_nxt;
    logic                r_busy, w_busy_nxt;

    logic [2*DATA_W-1:0] w_prod_s;
    logic [2*DATA_W-1:0] w_prod_u;
    logic [DATA_W-1:0]   w_quo_s, w_rem_s;
    logic [DATA_W-1:0]   w_quo_u, w_rem_u;
    logic                w_b_zero;
    logic                w_div_ovf;
    mdu_op_e             w_op;

    assign w_op      = mdu_op_e'(bus.mdu_op);
    assign w_b_zero  = (bus.src_b == '0);
    // Most-negative / -1 overflows the 32-bit quotient; MIPS yields the dividend, remainder 0.
    assign w_div_ovf = (bus.src_a == 32'h8000_0000) && (bus.src_b == 32'hFFFF_FFFF);

    // Full-width products on explicitly extended operands.
    assign w_prod_s = $signed({{DATA_W{bus.src_a[DATA_W-1]}}, bus.src_a})
                    * $signed({{DATA_W{bus.src_b[DATA_W-1]}}, bus.src_b});
    assign w_prod_u = {{DATA_W{1'b0}}, bus.src_a} * {{DATA_W{1'b0}}, bus.src_b};

    // Quotient/remainder; divide-by-zero results are never written back.
    always_comb begin
        w_quo_s = '0;
        w_rem_s = '0;
        w_quo_u = '0;
        w_rem_u = '0;
        if (!w_b_zero) begin
            w_quo_u = bus.src_a / bus.src_b;
            w_rem_u = bus.src_a % bus.src_b;
            if (w_div_ovf) begin
                w_quo_s = 32'h8000_0000;
                w_rem_s = '0;
            end else begin
                w_quo_s = DATA_W'($signed(bus.src_a) / $signed(bus.src_b));
                w_rem_s = DATA_W'($signed(bus.src_a) % $signed(bus.src_b));
            end
        end
    end

    // Next-state and register-update logic.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_hi_nxt      = r_hi;
        w_lo_nxt      = r_lo;
        w_hold_hi_nxt = r_hold_hi;
        w_hold_lo_nxt = r_hold_lo;
        w_hold_wr_nxt = r_hold_wr;
        w_busy_nxt    = r_busy;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    case (w_op)
                        OP_MULT, OP_MULTU: begin
                            {w_hold_hi_nxt, w_hold_lo_nxt} = (w_op == OP_MULT) ? w_prod_s : w_prod_u;
                            w_hold_wr_nxt = 1'b1;
                            w_cnt_nxt     = MULT_LOAD;
                            w_state_nxt   = ST_RUN;
                            w_busy_nxt    = 1'b1;
                        end
                        OP_DIV, OP_DIVU: begin
                            w_hold_hi_nxt = (w_op == OP_DIV) ? w_rem_s : w_rem_u;
                            w_hold_lo_nxt = (w_op == OP_DIV) ? w_quo_s : w_quo_u;
                            w_hold_wr_nxt = !w_b_zero;
                            w_cnt_nxt     = DIV_LOAD;
                            w_state_nxt   = ST_RUN;
                            w_busy_nxt    = 1'b1;
                        end
                        OP_MTHI: w_hi_nxt = bus.src_a;
                        OP_MTLO: w_lo_nxt = bus.src_a;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                // start is ignored here; the hazard unit keeps it low while busy.
                if (r_cnt == '0) begin
                    if (r_hold_wr) begin
                        w_hi_nxt = r_hold_hi;
                        w_lo_nxt = r_hold_lo;
                    end
                    w_hold_wr_nxt = 1'b0;
                    w_state_nxt   = ST_IDLE;
                    w_busy_nxt    = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State register; reset aborts any op in flight and drops its pending result.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_hold_hi <= '0;
            r_hold_lo <= '0;
            r_hold_wr <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_hi      <= w_hi_nxt;
            r_lo      <= w_lo_nxt;
            r_hold_hi <= w_hold_hi_nxt;
            r_hold_lo <= w_hold_lo_nxt;
            r_hold_wr <= w_hold_wr_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    assign bus.busy    = r_busy;
    assign bus.hi      = r_hi;
    assign bus.lo      = r_lo;
    assign bus.mdu_out = bus.rd_hi ? r_hi : r_lo;
endmodule
